// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared SVGA 800x600@60 timing constants, counter type and strobe decode
package vga_pkg;

    localparam int CNT_W    = 11;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic sync;
        logic blank;
    } axis_strobe_t;

    // Decode sync/blank for a given position along one axis.
    function automatic axis_strobe_t axis_strobes(
        input cnt_t count,
        input cnt_t blank_start,
        input cnt_t sync_start,
        input cnt_t sync_end
    );
        axis_strobe_t s;
        s.blank = (count >= blank_start);
        s.sync  = (count >= sync_start) && (count < sync_end);
        return s;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered sync/blank and wrap flag
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = vga_pkg::H_ACTIVE,
    parameter int FP     = vga_pkg::H_FP,
    parameter int SYNC   = vga_pkg::H_SYNC,
    parameter int BP     = vga_pkg::H_BP
) (
    input  logic pclk,
    input  logic rst,
    input  logic i_en,
    output cnt_t o_count,
    output logic o_sync,
    output logic o_blank,
    output logic o_wrap
);

    localparam int   TOTAL       = ACTIVE + FP + SYNC + BP;
    localparam cnt_t LAST        = cnt_t'(TOTAL - 1);
    localparam cnt_t BLANK_START = cnt_t'(ACTIVE);
    localparam cnt_t SYNC_START  = cnt_t'(ACTIVE + FP);
    localparam cnt_t SYNC_END    = cnt_t'(ACTIVE + FP + SYNC);

    cnt_t         r_count;
    logic         r_sync;
    logic         r_blank;
    cnt_t         w_count_next;
    axis_strobe_t w_strobe_next;

    assign o_wrap = i_en && (r_count == LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_en) begin
            w_count_next = (r_count == LAST) ? '0 : r_count + cnt_t'(1);
        end
    end

    // Strobes decode the next count so they land in the same cycle as the count itself.
    assign w_strobe_next = axis_strobes(w_count_next, BLANK_START, SYNC_START, SYNC_END);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_sync  <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_sync  <= w_strobe_next.sync;
            r_blank <= w_strobe_next.blank;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;
    assign o_blank = r_blank;

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - SVGA raster timing: pixel/line counters, syncs, blanks and frame_start pulse
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             pclk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             hblnk,
    output logic             vsync,
    output logic             vblnk,
    output logic             frame_start
);

    logic w_h_wrap;
    logic w_v_wrap;
    logic r_frame_start;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .pclk    (pclk),
        .rst     (rst),
        .i_en    (1'b1),
        .o_count (hcount),
        .o_sync  (hsync),
        .o_blank (hblnk),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .pclk    (pclk),
        .rst     (rst),
        .i_en    (w_h_wrap),
        .o_count (vcount),
        .o_sync  (vsync),
        .o_blank (vblnk),
        .o_wrap  (w_v_wrap)
    );

    // Only a wrap into (0,0) raises the pulse; the reset-state (0,0) never does.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
        end
    end

    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed self-checking bench: full-size line timing plus a shrunk raster for frame behaviour
module tb_vga_timing;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;

    logic [10:0] d_hcount, d_vcount;
    logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_frame_start;
    logic [10:0] s_hcount, s_vcount;
    logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing u_dut_full (
        .pclk        (pclk),
        .rst         (rst),
        .hcount      (d_hcount),
        .vcount      (d_vcount),
        .hsync       (d_hsync),
        .hblnk       (d_hblnk),
        .vsync       (d_vsync),
        .vblnk       (d_vblnk),
        .frame_start (d_frame_start)
    );

    // 25 x 10 raster (frame = 250 cycles): hsync 18..21, hblnk 16..24, vsync lines 7..8, vblnk lines 6..9
    vga_timing #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_dut_small (
        .pclk        (pclk),
        .rst         (rst),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hsync       (s_hsync),
        .hblnk       (s_hblnk),
        .vsync       (s_vsync),
        .vblnk       (s_vblnk),
        .frame_start (s_frame_start)
    );

    always begin
        #12 pclk = 1'b1;
        #13 pclk = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int d_seq_err = 0, s_seq_err = 0, d_vbad = 0;
        int hs_cnt = 0, hb_cnt = 0, hs_rise = -1, hs_fall = -1, hb_rise = -1, vc_step_hc = -1;
        int fs_cnt = 0, fs_first = -1, fs_last = -1, fs_bad = 0;
        int svs_cnt = 0, svb_cnt = 0, svs_rise_h = -1, svs_rise_v = -1;
        int vs_fall_last = -1, vs_int_n = 0, vs_int_bad = 0;
        logic prev_hs = 0, prev_hb = 0, prev_svs = 0;
        logic [10:0] prev_vc = 0;
        int found = 0, fs2_cnt = 0, fs2_first = -1;

        // reset held
        #30;
        chk("rst_hcount", 32'(d_hcount), 0);
        chk("rst_vcount", 32'(d_vcount), 0);
        chk("rst_hsync",  32'(d_hsync), 0);
        chk("rst_hblnk",  32'(d_hblnk), 0);
        chk("rst_vsync",  32'(d_vsync), 0);
        chk("rst_vblnk",  32'(d_vblnk), 0);
        chk("rst_fs",     32'(d_frame_start), 0);
        chk("rst_s_fs",   32'(s_frame_start), 0);

        @(negedge pclk);
        rst = 1'b0;
        @(posedge pclk);
        #1;
        chk("first_edge_hc", 32'(d_hcount), 1);
        chk("first_edge_vc", 32'(d_vcount), 0);

        for (int i = 1; i <= 2000; i++) begin
            @(negedge pclk);
            if (int'(d_hcount) != i % 1056 || int'(d_vcount) != i / 1056) d_seq_err++;
            if (int'(s_hcount) != i % 25 || int'(s_vcount) != (i / 25) % 10) s_seq_err++;
            if (i < 1056) begin
                if (d_hsync) hs_cnt++;
                if (d_hblnk) hb_cnt++;
            end
            if (d_hsync && !prev_hs && hs_rise < 0) hs_rise = int'(d_hcount);
            if (!d_hsync && prev_hs && hs_fall < 0) hs_fall = int'(d_hcount);
            if (d_hblnk && !prev_hb && hb_rise < 0) hb_rise = int'(d_hcount);
            if (d_vcount == 11'd1 && prev_vc == 11'd0) vc_step_hc = int'(d_hcount);
            if (d_vsync || d_vblnk || d_frame_start) d_vbad++;
            prev_hs = d_hsync;
            prev_hb = d_hblnk;
            prev_vc = d_vcount;

            if (s_frame_start) begin
                fs_cnt++;
                if (s_hcount != 0 || s_vcount != 0) fs_bad++;
                if (fs_first < 0) fs_first = i;
                else if (i - fs_last != 250) fs_bad++;
                fs_last = i;
            end
            if (i < 250) begin
                if (s_vsync) svs_cnt++;
                if (s_vblnk) svb_cnt++;
            end
            if (s_vsync && !prev_svs && svs_rise_h < 0) begin
                svs_rise_h = int'(s_hcount);
                svs_rise_v = int'(s_vcount);
            end
            if (!s_vsync && prev_svs) begin
                if (vs_fall_last >= 0) begin
                    vs_int_n++;
                    if (i - vs_fall_last != 250) vs_int_bad++;
                end
                vs_fall_last = i;
            end
            prev_svs = s_vsync;
        end

        chk("full_seq_err",   d_seq_err, 0);
        chk("hsync_len",      hs_cnt, 128);
        chk("hsync_rise_hc",  hs_rise, 840);
        chk("hsync_fall_hc",  hs_fall, 968);
        chk("hblnk_len",      hb_cnt, 256);
        chk("hblnk_rise_hc",  hb_rise, 800);
        chk("vcount_step_hc", vc_step_hc, 0);
        chk("full_vstrobes",  d_vbad, 0);
        chk("small_seq_err",  s_seq_err, 0);
        chk("fs_count",       fs_cnt, 8);
        chk("fs_first",       fs_first, 250);
        chk("fs_bad",         fs_bad, 0);
        chk("vsync_len",      svs_cnt, 50);
        chk("vblnk_len",      svb_cnt, 100);
        chk("vsync_rise_hc",  svs_rise_h, 0);
        chk("vsync_rise_vc",  svs_rise_v, 7);
        chk("vsync_intervals", vs_int_n, 7);
        chk("vsync_int_bad",  vs_int_bad, 0);

        // mid-line async reset at (944,1) of the full raster
        chk("pre_rst_hsync", 32'(d_hsync), 1);
        chk("pre_rst_s_fs",  32'(s_frame_start), 1);
        #3 rst = 1'b1;
        #2;
        chk("async_hcount", 32'(d_hcount), 0);
        chk("async_vcount", 32'(d_vcount), 0);
        chk("async_hsync",  32'(d_hsync), 0);
        chk("async_hblnk",  32'(d_hblnk), 0);
        chk("async_s_fs",   32'(s_frame_start), 0);
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        @(posedge pclk);
        #1;
        chk("restart_hc",   32'(d_hcount), 1);
        chk("restart_vc",   32'(d_vcount), 0);
        chk("restart_s_hc", 32'(s_hcount), 1);

        // reset asserted during the small raster's wrap cycle
        for (int j = 0; j < 400; j++) begin
            @(negedge pclk);
            if (s_hcount == 11'd24 && s_vcount == 11'd9) begin
                found = 1;
                break;
            end
        end
        chk("wrap_found", found, 1);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        chk("wrap_rst_hc", 32'(s_hcount), 0);
        chk("wrap_rst_vc", 32'(s_vcount), 0);
        chk("wrap_rst_fs", 32'(s_frame_start), 0);
        @(negedge pclk);
        rst = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            @(negedge pclk);
            if (s_frame_start) begin
                fs2_cnt++;
                if (fs2_first < 0) fs2_first = i;
            end
        end
        chk("post_wrap_fs_cnt",   fs2_cnt, 1);
        chk("post_wrap_fs_first", fs2_first, 250);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
